// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle data-memory responder for the MEM stage load/store port
// Accepts one byte/half/word access at a time, stalls the pipeline for LATENCY cycles, then pulses a response.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        stall_o
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d, write_q, write_d, err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] mem [DEPTH_WORDS];

  logic        in_idle, req_err, enter_resp, mem_we;
  logic [31:0] a_addr, a_wdata, rd_word, load_ext, wr_lanes;
  logic [1:0]  a_size;
  logic        a_signed, a_write, a_err;
  logic [3:0]  wr_be;
  logic [15:0] rd_half;
  logic [7:0]  rd_byte;
  logic [AW-1:0] word_idx;

  assign in_idle = (state_q == S_IDLE);
  assign req_err = (req_size_i == 2'b11)
                 | ((req_size_i == 2'b00) & (req_addr_i[1:0] != 2'b00))
                 | ((req_size_i == 2'b01) & req_addr_i[0])
                 | ({2'b00, req_addr_i[31:2]} >= 32'(DEPTH_WORDS));

  // The accept edge of a LATENCY=1 access is also its memory edge, so it must use the live inputs.
  assign a_addr   = in_idle ? req_addr_i   : addr_q;
  assign a_wdata  = in_idle ? req_wdata_i  : wdata_q;
  assign a_size   = in_idle ? req_size_i   : size_q;
  assign a_signed = in_idle ? req_signed_i : signed_q;
  assign a_write  = in_idle ? req_write_i  : write_q;
  assign a_err    = in_idle ? req_err      : err_q;

  assign word_idx = a_addr[AW+1:2];
  assign rd_word  = mem[word_idx];
  assign rd_half  = a_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    rd_byte = rd_word[7:0];
    case (a_addr[1:0])
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      2'd3:    rd_byte = rd_word[31:24];
      default: rd_byte = rd_word[7:0];
    endcase
    load_ext = 32'h0;
    wr_be    = 4'h0;
    wr_lanes = a_wdata;
    case (a_size)
      2'b00: begin
        load_ext = rd_word;
        wr_be    = 4'hF;
      end
      2'b01: begin
        load_ext = {{16{a_signed & rd_half[15]}}, rd_half};
        wr_be    = a_addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{a_wdata[15:0]}};
      end
      2'b10: begin
        load_ext = {{24{a_signed & rd_byte[7]}}, rd_byte};
        wr_be    = 4'b0001 << a_addr[1:0];
        wr_lanes = {4{a_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'h0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      write_q    <= write_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      resp_err_q <= resp_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    signed_d   = signed_q;
    write_d    = write_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    resp_err_d = resp_err_q;
    case (state_q)
      S_IDLE: if (req_valid_i) begin
        addr_d   = req_addr_i;
        wdata_d  = req_wdata_i;
        size_d   = req_size_i;
        signed_d = req_signed_i;
        write_d  = req_write_i;
        err_d    = req_err;
        if (LATENCY == 1) begin
          state_d = S_RESP;
        end else begin
          cnt_d   = 4'(LATENCY - 2);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
    enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
    if (enter_resp) begin
      rdata_d    = (a_err | a_write) ? 32'h0 : load_ext;
      resp_err_d = a_err;
    end
  end

  // A reset coinciding with the access edge aborts the store.
  assign mem_we = enter_resp & a_write & ~a_err & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  always_comb begin
    req_ready_o  = in_idle & ~rst_i;
    resp_valid_o = (state_q == S_RESP);
    stall_o      = req_valid_i & ~resp_valid_o;
    resp_rdata_o = rdata_q;
    resp_err_o   = resp_err_q;
  end

endmodule
